// File: rtl/uart_rx_cfg.sv
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Parametrised UART receiver (5-9 data bits, optional parity, 1/2
//            stop bits) with 3-sample majority vote and valid/ready delivery.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_cfg #(
    parameter int CLK_PER_BIT = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst,
    input  logic                 rx_en,
    input  logic                 rx_in,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int IDX_W = 4;
    localparam int MID   = CLK_PER_BIT / 2;

    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_mid_m1    = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] c_mid       = CNT_W'(MID);
    localparam logic [CNT_W-1:0] c_mid_p1    = CNT_W'(MID + 1);
    localparam logic [IDX_W-1:0] c_data_last = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] c_stop_last = IDX_W'(STOP_BITS - 1);
    localparam logic             c_par_odd   = (PARITY_ODD != 0);
    localparam logic             c_par_en    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   s0_q, s0_d, s1_q, s1_d;
    logic                   par_pend_q, par_pend_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   par_err_q, par_err_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;

    logic cnt_wrap, decide, maj, par_exp, frame_ok, frame_bad;

    assign cnt_wrap = (cnt_q == c_cnt_last);
    assign decide   = (cnt_q == c_mid_p1);
    // Third sample is the live synchronised value at the decision cycle.
    assign maj      = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
    assign par_exp  = (^shreg_q) ^ c_par_odd;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        par_pend_d = par_pend_q;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == c_mid_m1) s0_d = sync2_q;
            if (cnt_q == c_mid)    s1_d = sync2_q;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_en && !sync2_q && prev_q) begin
                    state_d    = S_START;
                    par_pend_d = 1'b0;
                end
            end
            S_START: begin
                if (decide && maj) begin
                    state_d = S_IDLE;
                end else if (cnt_wrap) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (decide) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                if (cnt_wrap) begin
                    if (idx_q == c_data_last) begin
                        idx_d   = '0;
                        state_d = c_par_en ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (decide) par_pend_d = (maj != par_exp);
                if (cnt_wrap) begin
                    idx_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // The final stop bit completes at its decision point, leaving
                // half a bit of slack for back-to-back frames.
                if (decide && !maj) begin
                    frame_bad = 1'b1;
                    state_d   = S_IDLE;
                end else if (decide && (idx_q == c_stop_last)) begin
                    frame_ok = 1'b1;
                    state_d  = S_IDLE;
                end else if (cnt_wrap) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!rx_en) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            idx_d     = '0;
            shreg_d   = '0;
            frame_ok  = 1'b0;
            frame_bad = 1'b0;
        end
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        par_err_d = par_err_q;
        ferr_d    = frame_bad;
        ovr_d     = 1'b0;
        if (valid_q && rx_ready) valid_d = 1'b0;
        if (frame_ok) begin
            if (!valid_q || rx_ready) begin
                data_d    = shreg_q;
                par_err_d = par_pend_q;
                valid_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            par_pend_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= rx_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            par_pend_q <= par_pend_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = par_err_q;
    assign rx_frame_err  = ferr_q;
    assign rx_overrun    = ovr_q;
    assign rx_busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// ============================================================================
// Module   : tb_uart_rx_cfg
// Brief    : Directed bench: default 8N1 receiver plus a 7-bit odd-parity,
//            two-stop-bit receiver, driven with hand-built serial frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en0, rx0, rdy0, rx1, rdy1;
    logic [7:0] rx_data0;
    logic [6:0] rx_data1;
    logic       rx_valid0, rx_perr0, rx_ferr0, rx_ovr0, rx_busy0;
    logic       rx_valid1, rx_perr1, rx_ferr1, rx_ovr1, rx_busy1;

    uart_rx_cfg u_dut0 (
        .rx_clk(clk), .rx_rst(rst), .rx_en(en0), .rx_in(rx0), .rx_ready(rdy0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_parity_err(rx_perr0),
        .rx_frame_err(rx_ferr0), .rx_overrun(rx_ovr0), .rx_busy(rx_busy0)
    );

    uart_rx_cfg #(
        .CLK_PER_BIT(16), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
    ) u_dut1 (
        .rx_clk(clk), .rx_rst(rst), .rx_en(1'b1), .rx_in(rx1), .rx_ready(rdy1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_parity_err(rx_perr1),
        .rx_frame_err(rx_ferr1), .rx_overrun(rx_ovr1), .rx_busy(rx_busy1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Free-running event counters; the main sequence only takes snapshots.
    int v0_rises = 0, v0_rise_cyc = 0, fe0_hi = 0, fe0_cyc = 0;
    int ov0_hi = 0, ov0_cyc = 0, busy0_hi = 0;
    int v1_rises = 0, v1_rise_cyc = 0, fe1_hi = 0;
    logic [7:0] v0_data = '0;
    logic [6:0] v1_data = '0;
    logic       v1_perr = 1'b0;
    logic       pv0 = 1'b0, pv1 = 1'b0;

    always @(negedge clk) begin
        if (rx_valid0 && !pv0) begin
            v0_rises++; v0_rise_cyc = cyc; v0_data = rx_data0;
        end
        pv0 = rx_valid0;
        if (rx_ferr0) begin fe0_hi++; fe0_cyc = cyc; end
        if (rx_ovr0)  begin ov0_hi++; ov0_cyc = cyc; end
        if (rx_busy0) busy0_hi++;
        if (rx_valid1 && !pv1) begin
            v1_rises++; v1_rise_cyc = cyc; v1_data = rx_data1; v1_perr = rx_perr1;
        end
        pv1 = rx_valid1;
        if (rx_ferr1) fe1_hi++;
    end

    int n_tests = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // act: 0 = none, 1 = drop rx_en in data bit 3, 2 = pulse rx_rst in data bit 3
    task automatic send(input int sel, input logic [8:0] data, input int nbits,
                        input int par_en, input logic par, input logic [1:0] stops,
                        input int nstop, input int act, output int fall);
        logic [15:0] fr;
        int n;
        fr = '1;
        n  = 0;
        fr[n] = 1'b0; n++;
        for (int i = 0; i < nbits; i++) begin fr[n] = data[i]; n++; end
        if (par_en != 0) begin fr[n] = par; n++; end
        for (int i = 0; i < nstop; i++) begin fr[n] = stops[i]; n++; end
        fall = 0;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (sel == 0) rx0 = fr[b]; else rx1 = fr[b];
                if (b == 0 && c == 0) fall = cyc;
                if (act == 1 && b == 4 && c == 10) en0 = 1'b0;
                if (act == 1 && b == 4 && c == 12) en0 = 1'b1;
                if (act == 2 && b == 4 && c == 10) rst = 1'b1;
                if (act == 2 && b == 4 && c == 12) rst = 1'b0;
                tick();
            end
        end
        if (sel == 0) rx0 = 1'b1; else rx1 = 1'b1;
    endtask

    int fall, fall2, snap_r, snap_f, snap_o, snap_b;

    initial begin
        rst = 1'b1; en0 = 1'b1; rx0 = 1'b1; rdy0 = 1'b1; rx1 = 1'b1; rdy1 = 1'b1;
        idle(5);
        check_eq("rst_data",  {24'd0, rx_data0}, 32'h0);
        check_eq("rst_valid", {31'd0, rx_valid0}, 32'h0);
        check_eq("rst_perr",  {31'd0, rx_perr0}, 32'h0);
        check_eq("rst_ferr",  {31'd0, rx_ferr0}, 32'h0);
        check_eq("rst_ovr",   {31'd0, rx_ovr0}, 32'h0);
        check_eq("rst_busy",  {31'd0, rx_busy0}, 32'h0);
        rst = 1'b0;
        idle(5);

        // Single default frame, consumer always ready.
        snap_r = v0_rises; snap_b = busy0_hi; snap_f = fe0_hi; snap_o = ov0_hi;
        send(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, 0, fall);
        idle(10);
        check_eq("a5_count", v0_rises - snap_r, 1);
        check_eq("a5_data",  {24'd0, v0_data}, 32'hA5);
        check_eq("a5_lat",   v0_rise_cyc - fall, 157);
        check_eq("a5_busy",  busy0_hi - snap_b, 154);
        check_eq("a5_valid_after", {31'd0, rx_valid0}, 32'h0);
        check_eq("a5_errs",  (fe0_hi - snap_f) + (ov0_hi - snap_o), 0);
        check_eq("a5_perr",  {31'd0, rx_perr0}, 32'h0);

        // 4-cycle low glitch is a false start.
        snap_r = v0_rises; snap_b = busy0_hi; snap_f = fe0_hi;
        rx0 = 1'b0; idle(4); rx0 = 1'b1;
        idle(40);
        check_eq("glitch_busy",  busy0_hi - snap_b, 10);
        check_eq("glitch_valid", v0_rises - snap_r, 0);
        check_eq("glitch_ferr",  fe0_hi - snap_f, 0);

        // Framing error, then a good frame.
        snap_r = v0_rises; snap_f = fe0_hi;
        send(0, 9'h03C, 8, 0, 1'b0, 2'b00, 1, 0, fall);
        idle(10);
        check_eq("fe_pulse", fe0_hi - snap_f, 1);
        check_eq("fe_lat",   fe0_cyc - fall, 157);
        check_eq("fe_valid", v0_rises - snap_r, 0);
        send(0, 9'h055, 8, 0, 1'b0, 2'b11, 1, 0, fall);
        idle(10);
        check_eq("fe_next_count", v0_rises - snap_r, 1);
        check_eq("fe_next_data",  {24'd0, v0_data}, 32'h55);

        // Parity on the 7O2 receiver: 0x41 has two ones, so odd parity bit = 1.
        snap_r = v1_rises;
        send(1, 9'h041, 7, 1, 1'b1, 2'b11, 2, 0, fall);
        idle(10);
        check_eq("p_ok_count", v1_rises - snap_r, 1);
        check_eq("p_ok_data",  {25'd0, v1_data}, 32'h41);
        check_eq("p_ok_perr",  {31'd0, v1_perr}, 32'h0);
        check_eq("p_ok_lat",   v1_rise_cyc - fall, 173);
        send(1, 9'h041, 7, 1, 1'b0, 2'b11, 2, 0, fall);
        idle(10);
        check_eq("p_bad_data", {25'd0, v1_data}, 32'h41);
        check_eq("p_bad_perr", {31'd0, v1_perr}, 32'h1);
        send(1, 9'h007, 7, 1, 1'b0, 2'b11, 2, 0, fall);
        idle(10);
        check_eq("p_07_data", {25'd0, v1_data}, 32'h07);
        check_eq("p_07_perr", {31'd0, v1_perr}, 32'h0);
        snap_r = v1_rises; snap_f = fe1_hi;
        send(1, 9'h041, 7, 1, 1'b1, 2'b01, 2, 0, fall);
        idle(10);
        check_eq("stop2_fe",    fe1_hi - snap_f, 1);
        check_eq("stop2_valid", v1_rises - snap_r, 0);

        // Overrun: consumer stalled, two back-to-back frames.
        rdy0 = 1'b0;
        snap_r = v0_rises; snap_o = ov0_hi;
        send(0, 9'h011, 8, 0, 1'b0, 2'b11, 1, 0, fall);
        send(0, 9'h022, 8, 0, 1'b0, 2'b11, 1, 0, fall2);
        idle(10);
        check_eq("ovr_count", v0_rises - snap_r, 1);
        check_eq("ovr_first", {24'd0, v0_data}, 32'h11);
        check_eq("ovr_pulse", ov0_hi - snap_o, 1);
        check_eq("ovr_lat",   ov0_cyc - fall2, 157);
        check_eq("ovr_held",  {24'd0, rx_data0}, 32'h11);
        check_eq("ovr_valid", {31'd0, rx_valid0}, 32'h1);
        rdy0 = 1'b1;
        tick();
        check_eq("ovr_accept", {31'd0, rx_valid0}, 32'h0);

        // rx_en abort keeps the held word.
        rdy0 = 1'b0;
        send(0, 9'h033, 8, 0, 1'b0, 2'b11, 1, 0, fall);
        idle(5);
        snap_r = v0_rises; snap_f = fe0_hi;
        send(0, 9'h0F0, 8, 0, 1'b0, 2'b11, 1, 1, fall);
        idle(20);
        check_eq("en_no_frame", v0_rises - snap_r, 0);
        check_eq("en_no_ferr",  fe0_hi - snap_f, 0);
        check_eq("en_held_v",   {31'd0, rx_valid0}, 32'h1);
        check_eq("en_held_d",   {24'd0, rx_data0}, 32'h33);
        rdy0 = 1'b1;
        tick();
        check_eq("en_accept", {31'd0, rx_valid0}, 32'h0);
        send(0, 9'h00F, 8, 0, 1'b0, 2'b11, 1, 0, fall);
        idle(10);
        check_eq("en_recover_n", v0_rises - snap_r, 1);
        check_eq("en_recover_d", {24'd0, v0_data}, 32'h0F);

        // rx_rst abort drops the held word.
        rdy0 = 1'b0;
        send(0, 9'h044, 8, 0, 1'b0, 2'b11, 1, 0, fall);
        idle(5);
        check_eq("rst_pre_held", {24'd0, rx_data0}, 32'h44);
        snap_r = v0_rises; snap_f = fe0_hi;
        send(0, 9'h0F0, 8, 0, 1'b0, 2'b11, 1, 2, fall);
        idle(20);
        check_eq("rst_lost_v",  {31'd0, rx_valid0}, 32'h0);
        check_eq("rst_lost_d",  {24'd0, rx_data0}, 32'h0);
        check_eq("rst_no_frame", v0_rises - snap_r, 0);
        check_eq("rst_no_ferr",  fe0_hi - snap_f, 0);
        rdy0 = 1'b1;
        send(0, 9'h00F, 8, 0, 1'b0, 2'b11, 1, 0, fall);
        idle(10);
        check_eq("rst_recover_n", v0_rises - snap_r, 1);
        check_eq("rst_recover_d", {24'd0, v0_data}, 32'h0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
